// File: rtl/tag_store_pkg.sv
// Shared types, default geometry and helpers for the set-associative tag store.
package tag_store_pkg;

  localparam int unsigned DefSets = 64;
  localparam int unsigned DefWays = 2;
  localparam int unsigned DefTagW = 6;
  localparam int unsigned SET_W   = $clog2(DefSets);
  localparam int unsigned WAY_W   = $clog2(DefWays);
  localparam int unsigned MaxWays = 8;

  typedef enum logic {StIdle, StFlush} state_e;

  // Lowest set bit index of a way vector (zero-extended to MaxWays).
  function automatic logic [2:0] first_one(input logic [MaxWays-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = MaxWays - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tag_store_lru_age_update.sv
// Next-age vector for one set after touching a way (true LRU, ages form a permutation).
module lru_age_update #(
  parameter int unsigned WAYS = 2
) (
  input  logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_i,
  input  logic [$clog2(WAYS)-1:0]           way_i,
  output logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_o
);

  localparam int unsigned WayW = $clog2(WAYS);

  always_comb begin
    ages_o = ages_i;
    for (int w = 0; w < WAYS; w++) begin
      if (WayW'(w) == way_i) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < ages_i[way_i]) begin
        ages_o[w] = ages_i[w] + WayW'(1);
      end
    end
  end

endmodule

// File: rtl/tag_store.sv
// Set-associative tag/metadata store with tag compare, true-LRU victim and flush sequencer.
// Optional parity protection on {valid, tag} is enabled with TAG_STORE_PARITY_EN.
module tag_store
  import tag_store_pkg::*;
#(
  parameter int unsigned SETS  = DefSets,
  parameter int unsigned WAYS  = DefWays,
  parameter int unsigned TAG_W = DefTagW
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [$clog2(SETS)-1:0] req_set_i,
  input  logic [TAG_W-1:0]        req_tag_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_hit_o,
  output logic [$clog2(WAYS)-1:0] rsp_way_o,
  output logic [$clog2(WAYS)-1:0] rsp_victim_o,
  input  logic                    fill_en_i,
  input  logic [$clog2(SETS)-1:0] fill_set_i,
  input  logic [$clog2(WAYS)-1:0] fill_way_i,
  input  logic [TAG_W-1:0]        fill_tag_i,
  input  logic                    flush_req_i,
  output logic                    flush_busy_o
`ifdef TAG_STORE_PARITY_EN
  ,
  output logic                    parity_err_o
`endif
);

  localparam int unsigned SetW = $clog2(SETS);
  localparam int unsigned WayW = $clog2(WAYS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WayW-1:0]  age;
`ifdef TAG_STORE_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  entry_t mem_q [SETS][WAYS];

  state_e          state_q;
  logic [SetW-1:0] ptr_q;
  logic            flush_busy_q, req_ready_q;
  logic            rsp_valid_q, rsp_hit_q;
  logic [WayW-1:0] rsp_way_q, rsp_victim_q;

  logic [WAYS-1:0]           hit_vec, inv_vec, old_vec;
  logic [WAYS-1:0][WayW-1:0] lk_ages, lk_ages_new, fill_ages, fill_ages_new;
  logic                      lk_hit, fault_any;
  logic [WayW-1:0]           lk_way, lk_victim, fault_way;
  logic                      accept, fill_do, hit_touch;

  always_comb begin
    hit_vec   = '0;
    inv_vec   = '0;
    old_vec   = '0;
    lk_ages   = '0;
    fill_ages = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w]   = mem_q[req_set_i][w].valid && (mem_q[req_set_i][w].tag == req_tag_i);
      inv_vec[w]   = !mem_q[req_set_i][w].valid;
      old_vec[w]   = mem_q[req_set_i][w].age == WayW'(WAYS - 1);
      lk_ages[w]   = mem_q[req_set_i][w].age;
      fill_ages[w] = mem_q[fill_set_i][w].age;
    end
  end

`ifdef TAG_STORE_PARITY_EN
  logic [WAYS-1:0] fault_vec;
  logic            parity_err_q;

  // Even parity: stored bit makes ^{valid, tag, parity} zero.
  always_comb begin
    fault_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      fault_vec[w] = mem_q[req_set_i][w].valid &&
                     (mem_q[req_set_i][w].parity !=
                      ^{mem_q[req_set_i][w].valid, mem_q[req_set_i][w].tag});
    end
  end
  assign fault_any    = |fault_vec;
  assign fault_way    = WayW'(first_one(MaxWays'(fault_vec)));
  assign parity_err_o = parity_err_q;
`else
  assign fault_any = 1'b0;
  assign fault_way = '0;
`endif

  always_comb begin
    lk_hit = (|hit_vec) && !fault_any;
    lk_way = lk_hit ? WayW'(first_one(MaxWays'(hit_vec))) : '0;
    if (fault_any) begin
      lk_victim = fault_way;
    end else if (|inv_vec) begin
      lk_victim = WayW'(first_one(MaxWays'(inv_vec)));
    end else begin
      lk_victim = WayW'(first_one(MaxWays'(old_vec)));
    end
  end

  assign accept    = req_valid_i && req_ready_q;
  assign fill_do   = fill_en_i && (state_q == StIdle);
  // A same-set fill owns the LRU update; the lookup's hit touch is dropped.
  assign hit_touch = accept && lk_hit && !(fill_do && (fill_set_i == req_set_i));

  lru_age_update #(
    .WAYS (WAYS)
  ) u_lru_hit (
    .ages_i (lk_ages),
    .way_i  (lk_way),
    .ages_o (lk_ages_new)
  );

  lru_age_update #(
    .WAYS (WAYS)
  ) u_lru_fill (
    .ages_i (fill_ages),
    .way_i  (fill_way_i),
    .ages_o (fill_ages_new)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem_q[s][w].valid  <= 1'b0;
          mem_q[s][w].tag    <= '0;
          mem_q[s][w].age    <= WayW'(w);
`ifdef TAG_STORE_PARITY_EN
          mem_q[s][w].parity <= 1'b0;
`endif
        end
      end
    end else if (state_q == StFlush) begin
      for (int w = 0; w < WAYS; w++) begin
        mem_q[ptr_q][w].valid <= 1'b0;
        mem_q[ptr_q][w].age   <= WayW'(w);
      end
    end else begin
      if (hit_touch) begin
        for (int w = 0; w < WAYS; w++) mem_q[req_set_i][w].age <= lk_ages_new[w];
      end
      if (fill_do) begin
        mem_q[fill_set_i][fill_way_i].valid  <= 1'b1;
        mem_q[fill_set_i][fill_way_i].tag    <= fill_tag_i;
`ifdef TAG_STORE_PARITY_EN
        mem_q[fill_set_i][fill_way_i].parity <= ^{1'b1, fill_tag_i};
`endif
        for (int w = 0; w < WAYS; w++) mem_q[fill_set_i][w].age <= fill_ages_new[w];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      flush_busy_q <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_victim_q <= '0;
`ifdef TAG_STORE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q  <= accept;
      rsp_hit_q    <= accept && lk_hit;
      rsp_way_q    <= accept ? lk_way : '0;
      rsp_victim_q <= accept ? lk_victim : '0;
`ifdef TAG_STORE_PARITY_EN
      parity_err_q <= accept && fault_any;
`endif
      unique case (state_q)
        StIdle: begin
          if (flush_req_i) begin
            state_q      <= StFlush;
            ptr_q        <= '0;
            flush_busy_q <= 1'b1;
            req_ready_q  <= 1'b0;
          end
        end
        StFlush: begin
          ptr_q <= ptr_q + SetW'(1);
          if (ptr_q == SetW'(SETS - 1)) begin
            state_q      <= StIdle;
            flush_busy_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign flush_busy_o = flush_busy_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_way_o    = rsp_way_q;
  assign rsp_victim_o = rsp_victim_q;

endmodule
